playfield_pixel_pipeline: RTL and testbench
===========================================

// Module: playfield_pixel_pipeline
// PURPOSE
//  Pipelined, parametrised playfield renderer for the VGA path.
//  Maps the current VGA pixel to a playfield tile and looks up that tile's colour.
//  Adds three things: optional grid lines, an outline-only ghost mode, and a
//  frame-counted line-clear flash animation with a start/busy/done handshake.
//  Sits between the VGA timing generator and the display colour mux.
//  Uses DisplayPkg tile_type_t and colour constants.
// PARAMETERS
//  ROWS          20         playfield rows (tile_type first index)
//  COLS          10         playfield columns
//  TILE_W        20         tile width in pixels
//  TILE_H        20         tile height in pixels
//  HSTART        220        first playfield pixel column
//  VSTART        40         first playfield pixel row
//  GRID_EN       1          draw GRID_COLOR on the top/left edge pixel of BLANK tiles
//  GRID_COLOR    24'h202020 grid line colour
//  GHOST_OUTLINE 1          GHOST drawn on tile edge pixels only; interior shows TILE_BLANK_COLOR
//  FLASH_FRAMES  8          frames per flash phase
//  FLASH_PHASES  6          phase toggles per clear animation (must be even, >=2)
//  FLASH_COLOR   24'hFFFFFF colour of clearing rows during the "on" phase
// PORTS
//  clk           in   1          pixel clock
//  rst           in   1          asynchronous, active-high reset
//  VGA_row       in   10         current pixel row
//  VGA_col       in   10         current pixel column
//  frame_start   in   1          one-cycle pulse per frame (at row 0, col 0)
//  tile_type     in   ROWSxCOLS  tile_type_t board contents
//  clear_start   in   1          pulse: begin flash animation on clear_rows
//  clear_rows    in   ROWS       bitmask of rows to flash; bit i = row i
//  output_color  out  24         RGB for the pixel presented 3 cycles earlier
//  active        out  1          pixel presented 3 cycles earlier lies in the playfield
//  clear_busy    out  1          animation in progress
//  clear_done    out  1          one-cycle pulse when the animation ends
// BEHAVIOUR
//  Reset (async, rst=1):
//   - output_color=0, active=0, clear_busy=0, clear_done=0.
//   - All pipeline valid bits 0; FSM in IDLE; frame and phase counters 0; captured mask 0.
//  Pipeline, fixed 3-cycle latency, one pixel per clock, no stalls:
//   - S1: dr=VGA_row-VSTART and dc=VGA_col-HSTART (11-bit).
//     in_field = VGA_row>=VSTART && VGA_row<VSTART+ROWS*TILE_H, and likewise for columns.
//     Bounds are GEQ low / strict LT high.
//   - S2: tile_r=dr/TILE_H and tile_c=dc/TILE_W (constant-divisor compare ladders, no divider).
//     Local offsets lr=dr-tile_r*TILE_H and lc=dc-tile_c*TILE_W.
//     edge = lr==0 || lc==0 || lr==TILE_H-1 || lc==TILE_W-1.
//   - S3: register the colour and active=in_field.
//     Out of field: output_color=0.
//  Colour priority (S3, in field):
//   1. flash_on && mask[tile_r] -> FLASH_COLOR
//   2. GARBAGE, I, O, T, J, L, S, Z -> their DisplayPkg colours
//   3. GHOST -> TILE_GHOST_COLOR.
//      If GHOST_OUTLINE, only when edge is set; otherwise TILE_BLANK_COLOR.
//   4. BLANK/other -> GRID_COLOR if GRID_EN && (lr==0 || lc==0); otherwise TILE_BLANK_COLOR.
//  tile_type is sampled at S2; the board must be held stable within a frame.
//  Clear FSM:
//   - IDLE:
//     - clear_start=1 && clear_rows!=0: capture mask=clear_rows; phase=0; frame counter=0;
//       flash_on=1; clear_busy=1; go to FLASH.
//     - clear_start with clear_rows==0: go directly to DONE (done pulse, no flash).
//   - FLASH, on each frame_start:
//     - frame counter++.
//     - When it reaches FLASH_FRAMES-1: reset it, toggle flash_on, phase++.
//     - When phase reaches FLASH_PHASES: go to DONE.
//   - DONE: clear_done=1 for exactly one cycle; clear_busy=0; flash_on=0; mask=0; next IDLE.
//   - clear_start while busy (FLASH or DONE) is ignored.
//   - clear_start and frame_start in the same cycle while IDLE: capture only.
//     That frame_start is not counted.
//   - The animation never changes active and never alters out-of-field pixels.
//  Reset mid-animation aborts at once: mask cleared, clear_done not pulsed.
// TESTING
//  1. Reset, then sweep the frame:
//     - active=1 exactly for rows 40..439 and cols 220..419.
//     - Data arrives with 3 cycles of latency.
//     - Col 419 is in field; col 420 is out.
//  2. Board with tile[0][0]=I and tile[19][9]=Z:
//     - Pixel (45,225) -> TETROMINO_I_COLOR.
//     - Pixel (435,415) -> TETROMINO_Z_COLOR.
//     - Pixel (40,240) of a blank tile -> GRID_COLOR.
//  3. GHOST at tile[5][3]:
//     - Edge pixel (140,280) -> TILE_GHOST_COLOR.
//     - Interior pixel (150,290) -> TILE_BLANK_COLOR.
//  4. clear_rows=20'h80000 (row 19), pulse clear_start:
//     - busy rises next cycle; row 19 pixels alternate FLASH_COLOR every 8 frames.
//     - Other rows are unchanged.
//     - clear_done pulses once after 48 frame_starts; busy falls.
//  5. Second clear_start mid-animation is ignored (done timing unchanged).
//     clear_start with clear_rows=0 -> done pulse 2 cycles later, no flash.
//  6. Assert rst during FLASH: all outputs 0 immediately; no clear_done.
//     Next clear_start works normally.

Source files
------------

// File: rtl/playfield_pixel_pipeline_if.sv
// Pixel, board and clear-handshake bundle between the VGA timing path and the playfield renderer.
// tile_type is carried as raw 4-bit codes; the renderer interprets them as DisplayPkg::tile_type_t.
interface playfield_pixel_pipeline_if #(
   parameter int unsigned ROWS = 20,
   parameter int unsigned COLS = 10
);
   logic [9:0]      VGA_row;
   logic [9:0]      VGA_col;
   logic            frame_start;
   logic [3:0]      tile_type [ROWS][COLS];
   logic            clear_start;
   logic [ROWS-1:0] clear_rows;
   logic [23:0]     output_color;
   logic            active;
   logic            clear_busy;
   logic            clear_done;

   modport master (
      output VGA_row, VGA_col, frame_start, tile_type, clear_start, clear_rows,
      input  output_color, active, clear_busy, clear_done
   );

   modport slave (
      input  VGA_row, VGA_col, frame_start, tile_type, clear_start, clear_rows,
      output output_color, active, clear_busy, clear_done
   );
endinterface

// File: rtl/playfield_pixel_pipeline.sv
// Playfield renderer: 3-stage pixel->tile->colour pipeline with grid lines, ghost outline
// and a frame-counted line-clear flash animation.
package DisplayPkg;
   typedef enum logic [3:0] {
      TILE_BLANK   = 4'd0,
      TILE_GARBAGE = 4'd1,
      TILE_I       = 4'd2,
      TILE_O       = 4'd3,
      TILE_T       = 4'd4,
      TILE_J       = 4'd5,
      TILE_L       = 4'd6,
      TILE_S       = 4'd7,
      TILE_Z       = 4'd8,
      TILE_GHOST   = 4'd9
   } tile_type_t;

   localparam logic [23:0] TILE_BLANK_COLOR   = 24'h101010;
   localparam logic [23:0] TILE_GHOST_COLOR   = 24'h606060;
   localparam logic [23:0] TILE_GARBAGE_COLOR = 24'h808080;
   localparam logic [23:0] TETROMINO_I_COLOR  = 24'h00FFFF;
   localparam logic [23:0] TETROMINO_O_COLOR  = 24'hFFFF00;
   localparam logic [23:0] TETROMINO_T_COLOR  = 24'h800080;
   localparam logic [23:0] TETROMINO_J_COLOR  = 24'h0000FF;
   localparam logic [23:0] TETROMINO_L_COLOR  = 24'hFF8000;
   localparam logic [23:0] TETROMINO_S_COLOR  = 24'h00FF00;
   localparam logic [23:0] TETROMINO_Z_COLOR  = 24'hFF0000;
endpackage

module playfield_pixel_pipeline
   import DisplayPkg::*;
#(
   parameter int unsigned ROWS          = 20,
   parameter int unsigned COLS          = 10,
   parameter int unsigned TILE_W        = 20,
   parameter int unsigned TILE_H        = 20,
   parameter int unsigned HSTART        = 220,
   parameter int unsigned VSTART        = 40,
   parameter bit          GRID_EN       = 1'b1,
   parameter logic [23:0] GRID_COLOR    = 24'h202020,
   parameter bit          GHOST_OUTLINE = 1'b1,
   parameter int unsigned FLASH_FRAMES  = 8,
   parameter int unsigned FLASH_PHASES  = 6,
   parameter logic [23:0] FLASH_COLOR   = 24'hFFFFFF
) (
   input logic clk,
   input logic rst,
   playfield_pixel_pipeline_if.slave bus
);
   localparam int unsigned FIELD_H = ROWS * TILE_H;
   localparam int unsigned FIELD_W = COLS * TILE_W;
   localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW      = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned FW      = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam int unsigned PW      = $clog2(FLASH_PHASES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_FLASH, ST_DONE} state_t;

   state_t          state;
   logic [FW-1:0]   frame_cnt;
   logic [PW-1:0]   phase;
   logic [ROWS-1:0] mask;
   logic            flash_on;

   logic            s1_valid, s1_in_field;
   logic [10:0]     s1_dr, s1_dc;
   logic            s2_valid, s2_in_field, s2_edge, s2_grid;
   logic [RW-1:0]   s2_tile_r;
   tile_type_t      s2_tile;

   logic [10:0]     row_c, col_c;
   logic            in_field_c;
   logic [RW-1:0]   tile_r_c;
   logic [CW-1:0]   tile_c_c;
   logic [10:0]     lr_c, lc_c;
   logic [23:0]     color_c;

   assign row_c      = {1'b0, bus.VGA_row};
   assign col_c      = {1'b0, bus.VGA_col};
   assign in_field_c = (row_c >= 11'(VSTART)) && (row_c < 11'(VSTART + FIELD_H)) &&
                       (col_c >= 11'(HSTART)) && (col_c < 11'(HSTART + FIELD_W));

   // Constant-divisor ladders: tile index is the number of tile boundaries at or below the offset.
   always_comb begin
      tile_r_c = '0;
      tile_c_c = '0;
      for (int unsigned k = 1; k < ROWS; k++)
         if (s1_dr >= 11'(k * TILE_H)) tile_r_c = RW'(k);
      for (int unsigned k = 1; k < COLS; k++)
         if (s1_dc >= 11'(k * TILE_W)) tile_c_c = CW'(k);
      lr_c = s1_dr - 11'(32'(tile_r_c) * TILE_H);
      lc_c = s1_dc - 11'(32'(tile_c_c) * TILE_W);
   end

   always_comb begin
      color_c = TILE_BLANK_COLOR;
      if (!s2_in_field) begin
         color_c = '0;
      end else if (flash_on && mask[s2_tile_r]) begin
         color_c = FLASH_COLOR;
      end else begin
         case (s2_tile)
            TILE_GARBAGE: color_c = TILE_GARBAGE_COLOR;
            TILE_I:       color_c = TETROMINO_I_COLOR;
            TILE_O:       color_c = TETROMINO_O_COLOR;
            TILE_T:       color_c = TETROMINO_T_COLOR;
            TILE_J:       color_c = TETROMINO_J_COLOR;
            TILE_L:       color_c = TETROMINO_L_COLOR;
            TILE_S:       color_c = TETROMINO_S_COLOR;
            TILE_Z:       color_c = TETROMINO_Z_COLOR;
            TILE_GHOST:   color_c = (!GHOST_OUTLINE || s2_edge) ? TILE_GHOST_COLOR : TILE_BLANK_COLOR;
            default:      color_c = (GRID_EN && s2_grid) ? GRID_COLOR : TILE_BLANK_COLOR;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid         <= 1'b0;
         s1_in_field      <= 1'b0;
         s1_dr            <= '0;
         s1_dc            <= '0;
         s2_valid         <= 1'b0;
         s2_in_field      <= 1'b0;
         s2_edge          <= 1'b0;
         s2_grid          <= 1'b0;
         s2_tile_r        <= '0;
         s2_tile          <= TILE_BLANK;
         bus.output_color <= '0;
         bus.active       <= 1'b0;
      end else begin
         s1_valid         <= 1'b1;
         s1_in_field      <= in_field_c;
         s1_dr            <= row_c - 11'(VSTART);
         s1_dc            <= col_c - 11'(HSTART);
         s2_valid         <= s1_valid;
         s2_in_field      <= s1_in_field;
         s2_tile_r        <= tile_r_c;
         s2_tile          <= tile_type_t'(bus.tile_type[tile_r_c][tile_c_c]);
         s2_edge          <= (lr_c == '0) || (lc_c == '0) ||
                             (lr_c == 11'(TILE_H - 1)) || (lc_c == 11'(TILE_W - 1));
         s2_grid          <= (lr_c == '0) || (lc_c == '0);
         bus.output_color <= s2_valid ? color_c : '0;
         bus.active       <= s2_valid && s2_in_field;
      end
   end

   // Clear animation: a start with an empty mask skips straight to the done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         frame_cnt      <= '0;
         phase          <= '0;
         mask           <= '0;
         flash_on       <= 1'b0;
         bus.clear_busy <= 1'b0;
         bus.clear_done <= 1'b0;
      end else begin
         bus.clear_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.clear_start) begin
                  if (bus.clear_rows != '0) begin
                     mask           <= bus.clear_rows;
                     phase          <= '0;
                     frame_cnt      <= '0;
                     flash_on       <= 1'b1;
                     bus.clear_busy <= 1'b1;
                     state          <= ST_FLASH;
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_FLASH: begin
               if (bus.frame_start) begin
                  if (frame_cnt == FW'(FLASH_FRAMES - 1)) begin
                     frame_cnt <= '0;
                     flash_on  <= !flash_on;
                     phase     <= phase + PW'(1);
                     if (phase == PW'(FLASH_PHASES - 1)) state <= ST_DONE;
                  end else begin
                     frame_cnt <= frame_cnt + FW'(1);
                  end
               end
            end
            ST_DONE: begin
               bus.clear_done <= 1'b1;
               bus.clear_busy <= 1'b0;
               flash_on       <= 1'b0;
               mask           <= '0;
               state          <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_playfield_pixel_pipeline.sv
// Randomised self-checking bench for playfield_pixel_pipeline against a tile-arithmetic model.
module tb_playfield_pixel_pipeline;
   import DisplayPkg::*;

   localparam int ROWS = 20;
   localparam int COLS = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   playfield_pixel_pipeline_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
   playfield_pixel_pipeline dut (.clk(clk), .rst(rst), .bus(bus));

   int passed = 0;
   int total  = 0;

   tile_type_t      board [ROWS][COLS];
   logic            m_flash;
   logic [ROWS-1:0] m_mask;
   int              pr[$];
   int              pc[$];
   logic [23:0]     oc[$];
   logic            oa[$];

   function automatic logic exp_active(int r, int c);
      return (r >= 40 && r < 440 && c >= 220 && c < 420);
   endfunction

   // Reference colour from plain tile arithmetic on the board copy.
   function automatic logic [23:0] exp_color(int r, int c);
      int tr, tc, lr, lc;
      if (!exp_active(r, c)) return 24'h0;
      tr = (r - 40) / 20;
      tc = (c - 220) / 20;
      lr = (r - 40) % 20;
      lc = (c - 220) % 20;
      if (m_flash && m_mask[tr]) return 24'hFFFFFF;
      case (board[tr][tc])
         TILE_GARBAGE: return TILE_GARBAGE_COLOR;
         TILE_I:       return TETROMINO_I_COLOR;
         TILE_O:       return TETROMINO_O_COLOR;
         TILE_T:       return TETROMINO_T_COLOR;
         TILE_J:       return TETROMINO_J_COLOR;
         TILE_L:       return TETROMINO_L_COLOR;
         TILE_S:       return TETROMINO_S_COLOR;
         TILE_Z:       return TETROMINO_Z_COLOR;
         TILE_GHOST:   return (lr == 0 || lc == 0 || lr == 19 || lc == 19) ? TILE_GHOST_COLOR : TILE_BLANK_COLOR;
         default:      return (lr == 0 || lc == 0) ? 24'h202020 : TILE_BLANK_COLOR;
      endcase
   endfunction

   task automatic load_board();
      @(posedge clk); #1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            bus.tile_type[r][c] = 4'(board[r][c]);
   endtask

   task automatic clear_board();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            board[r][c] = TILE_BLANK;
   endtask

   // Random pixels: mostly in-field, optionally biased toward one tile row.
   task automatic add_random(int n, int tr_force);
      int sel, tr;
      for (int i = 0; i < n; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0) begin
            pr.push_back(int'($urandom_range(0, 479)));
            pc.push_back(int'($urandom_range(0, 639)));
         end else begin
            tr = (tr_force >= 0 && sel < 5) ? tr_force : int'($urandom_range(0, ROWS - 1));
            pr.push_back(40 + tr * 20 + int'($urandom_range(0, 19)));
            pc.push_back(220 + int'($urandom_range(0, 199)));
         end
      end
   endtask

   // Drives queued pixels one per clock and records what emerges 3 clocks later.
   task automatic stream();
      int n;
      n = pr.size();
      oc.delete();
      oa.delete();
      for (int i = 0; i < n + 3; i++) begin
         @(posedge clk); #1;
         if (i >= 3) begin
            oc.push_back(bus.output_color);
            oa.push_back(bus.active);
         end
         if (i < n) begin
            bus.VGA_row = 10'(pr[i]);
            bus.VGA_col = 10'(pc[i]);
         end
      end
   endtask

   task automatic pulse_frame();
      @(posedge clk); #1;
      bus.frame_start = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.VGA_row = 10'd100;
      bus.VGA_col = 10'd300;
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.output_color !== 24'h0) $display("FAIL reset_color: got %h expected 000000", bus.output_color); else passed++;
      total++; if (bus.active !== 1'b0) $display("FAIL reset_active: got %b expected 0", bus.active); else passed++;
      total++; if (bus.clear_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.clear_busy); else passed++;
      total++; if (bus.clear_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.clear_done); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_sweep();
      int rows[6];
      int cols[6];
      rows = '{0, 39, 40, 439, 440, 479};
      cols = '{0, 219, 220, 419, 420, 639};
      clear_board();
      load_board();
      pr.delete(); pc.delete();
      foreach (rows[i]) foreach (cols[j]) begin
         pr.push_back(rows[i]);
         pc.push_back(cols[j]);
      end
      add_random(40, -1);
      stream();
      foreach (pr[i]) begin
         total++; if (oa[i] !== exp_active(pr[i], pc[i])) $display("FAIL sweep_active(%0d,%0d): got %b expected %b", pr[i], pc[i], oa[i], exp_active(pr[i], pc[i])); else passed++;
         total++; if (oc[i] !== exp_color(pr[i], pc[i])) $display("FAIL sweep_color(%0d,%0d): got %h expected %h", pr[i], pc[i], oc[i], exp_color(pr[i], pc[i])); else passed++;
      end
   endtask

   task automatic test_tiles();
      clear_board();
      board[0][0]  = TILE_I;
      board[19][9] = TILE_Z;
      for (int k = 0; k < 30; k++)
         board[$urandom_range(1, 18)][$urandom_range(0, 9)] = tile_type_t'(4'($urandom_range(0, 8)));
      load_board();
      pr.delete(); pc.delete();
      pr.push_back(45);  pc.push_back(225);
      pr.push_back(435); pc.push_back(415);
      pr.push_back(40);  pc.push_back(240);
      add_random(60, -1);
      stream();
      total++; if (oc[0] !== TETROMINO_I_COLOR) $display("FAIL tile_I: got %h expected %h", oc[0], TETROMINO_I_COLOR); else passed++;
      total++; if (oc[1] !== TETROMINO_Z_COLOR) $display("FAIL tile_Z: got %h expected %h", oc[1], TETROMINO_Z_COLOR); else passed++;
      total++; if (oc[2] !== 24'h202020) $display("FAIL grid_edge: got %h expected 202020", oc[2]); else passed++;
      foreach (pr[i]) begin
         total++; if (oc[i] !== exp_color(pr[i], pc[i])) $display("FAIL tiles_color(%0d,%0d): got %h expected %h", pr[i], pc[i], oc[i], exp_color(pr[i], pc[i])); else passed++;
      end
   endtask

   task automatic test_ghost();
      board[5][3] = TILE_GHOST;
      load_board();
      pr.delete(); pc.delete();
      pr.push_back(140); pc.push_back(280);
      pr.push_back(150); pc.push_back(290);
      for (int i = 0; i < 30; i++) begin
         pr.push_back(140 + int'($urandom_range(0, 19)));
         pc.push_back(280 + int'($urandom_range(0, 19)));
      end
      stream();
      total++; if (oc[0] !== TILE_GHOST_COLOR) $display("FAIL ghost_edge: got %h expected %h", oc[0], TILE_GHOST_COLOR); else passed++;
      total++; if (oc[1] !== TILE_BLANK_COLOR) $display("FAIL ghost_interior: got %h expected %h", oc[1], TILE_BLANK_COLOR); else passed++;
      foreach (pr[i]) begin
         total++; if (oc[i] !== exp_color(pr[i], pc[i])) $display("FAIL ghost_color(%0d,%0d): got %h expected %h", pr[i], pc[i], oc[i], exp_color(pr[i], pc[i])); else passed++;
      end
   endtask

   // Full animation; a second start with a different mask is injected mid-way and must be ignored.
   task automatic test_flash(logic [ROWS-1:0] rows);
      int first, cnt, focus;
      focus = 0;
      for (int i = 0; i < ROWS; i++) if (rows[i]) focus = i;
      @(posedge clk); #1;
      bus.clear_rows  = rows;
      bus.clear_start = 1'b1;
      @(posedge clk); #1;
      bus.clear_start = 1'b0;
      total++; if (bus.clear_busy !== 1'b1) $display("FAIL flash_busy_rise: got %b expected 1", bus.clear_busy); else passed++;
      m_mask  = rows;
      m_flash = 1'b1;
      for (int n = 1; n <= 48; n++) begin
         if (n == 10) begin
            @(posedge clk); #1;
            bus.clear_rows  = ~rows;
            bus.clear_start = 1'b1;
            @(posedge clk); #1;
            bus.clear_start = 1'b0;
         end
         if (n < 48) begin
            pr.delete(); pc.delete();
            add_random(6, focus);
            stream();
            foreach (pr[i]) begin
               total++; if (oc[i] !== exp_color(pr[i], pc[i])) $display("FAIL flash_color n=%0d (%0d,%0d): got %h expected %h", n - 1, pr[i], pc[i], oc[i], exp_color(pr[i], pc[i])); else passed++;
               total++; if (oa[i] !== exp_active(pr[i], pc[i])) $display("FAIL flash_active(%0d,%0d): got %b expected %b", pr[i], pc[i], oa[i], exp_active(pr[i], pc[i])); else passed++;
            end
         end
         pulse_frame();
         total++; if (bus.clear_busy !== 1'b1) $display("FAIL flash_busy n=%0d: got %b expected 1", n, bus.clear_busy); else passed++;
         total++; if (bus.clear_done !== 1'b0) $display("FAIL flash_early_done n=%0d: got %b expected 0", n, bus.clear_done); else passed++;
         m_flash = ((n / 8) % 2) == 0;
      end
      first = -1;
      cnt   = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (bus.clear_done === 1'b1) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      total++; if (first !== 1) $display("FAIL flash_done_latency: got %0d expected 1", first); else passed++;
      total++; if (cnt !== 1) $display("FAIL flash_done_count: got %0d expected 1", cnt); else passed++;
      total++; if (bus.clear_busy !== 1'b0) $display("FAIL flash_busy_fall: got %b expected 0", bus.clear_busy); else passed++;
      m_flash = 1'b0;
      m_mask  = '0;
      pr.delete(); pc.delete();
      add_random(10, focus);
      stream();
      foreach (pr[i]) begin
         total++; if (oc[i] !== exp_color(pr[i], pc[i])) $display("FAIL after_flash_color(%0d,%0d): got %h expected %h", pr[i], pc[i], oc[i], exp_color(pr[i], pc[i])); else passed++;
      end
   endtask

   task automatic test_clear_empty();
      @(posedge clk); #1;
      bus.clear_rows  = '0;
      bus.clear_start = 1'b1;
      @(posedge clk); #1;
      bus.clear_start = 1'b0;
      total++; if (bus.clear_busy !== 1'b0) $display("FAIL empty_busy: got %b expected 0", bus.clear_busy); else passed++;
      total++; if (bus.clear_done !== 1'b0) $display("FAIL empty_done_early: got %b expected 0", bus.clear_done); else passed++;
      @(posedge clk); #1;
      total++; if (bus.clear_done !== 1'b1) $display("FAIL empty_done: got %b expected 1", bus.clear_done); else passed++;
      @(posedge clk); #1;
      total++; if (bus.clear_done !== 1'b0) $display("FAIL empty_done_width: got %b expected 0", bus.clear_done); else passed++;
      pr.delete(); pc.delete();
      add_random(20, -1);
      stream();
      foreach (pr[i]) begin
         total++; if (oc[i] !== exp_color(pr[i], pc[i])) $display("FAIL empty_color(%0d,%0d): got %h expected %h", pr[i], pc[i], oc[i], exp_color(pr[i], pc[i])); else passed++;
      end
   endtask

   task automatic test_reset_mid();
      int cnt;
      logic [ROWS-1:0] rows;
      rows = ROWS'($urandom) | 20'h00001;
      @(posedge clk); #1;
      bus.clear_rows  = rows;
      bus.clear_start = 1'b1;
      @(posedge clk); #1;
      bus.clear_start = 1'b0;
      bus.VGA_row = 10'd40;
      bus.VGA_col = 10'd230;
      repeat (5) pulse_frame();
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      total++; if (bus.output_color !== 24'h0) $display("FAIL midrst_color: got %h expected 000000", bus.output_color); else passed++;
      total++; if (bus.active !== 1'b0) $display("FAIL midrst_active: got %b expected 0", bus.active); else passed++;
      total++; if (bus.clear_busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus.clear_busy); else passed++;
      total++; if (bus.clear_done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", bus.clear_done); else passed++;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (bus.clear_done === 1'b1 || bus.clear_busy === 1'b1) cnt++;
      end
      total++; if (cnt !== 0) $display("FAIL midrst_no_done: got %0d cycles with done/busy expected 0", cnt); else passed++;
      m_flash = 1'b0;
      m_mask  = '0;
      pr.delete(); pc.delete();
      add_random(20, 0);
      stream();
      foreach (pr[i]) begin
         total++; if (oc[i] !== exp_color(pr[i], pc[i])) $display("FAIL midrst_color(%0d,%0d): got %h expected %h", pr[i], pc[i], oc[i], exp_color(pr[i], pc[i])); else passed++;
      end
   endtask

   initial begin
      bus.VGA_row     = '0;
      bus.VGA_col     = '0;
      bus.frame_start = 1'b0;
      bus.clear_start = 1'b0;
      bus.clear_rows  = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            bus.tile_type[r][c] = 4'd0;
      m_flash = 1'b0;
      m_mask  = '0;
      clear_board();
      test_reset();
      test_sweep();
      test_tiles();
      test_ghost();
      test_flash(20'h80000);
      test_clear_empty();
      test_reset_mid();
      test_flash(ROWS'($urandom) | 20'h00010);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
